// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a length-prefixed, XOR-checksummed byte
// stream into little-endian 32-bit words and writes them into progMem.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  pm_we,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [31:0]           pm_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned IDX_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_in_ready;
  logic                  r_pm_we;
  logic [ADDR_WIDTH-1:0] r_pm_addr;
  logic [31:0]           r_pm_wdata;
  logic                  r_core_hold;
  logic                  r_done;
  logic                  r_error;

  logic [15:0]           r_len;
  logic [IDX_W-1:0]      r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_asm;
  logic [7:0]            r_csum;

  logic                  w_accept;
  logic                  w_start_ok;
  logic [15:0]           w_len_full;
  logic                  w_len_over;
  logic                  w_last_word;
  logic                  w_csum_ok;
  logic                  w_in_ready_nxt;
  logic                  w_core_hold_nxt;
  logic                  w_done_nxt;
  logic                  w_error_nxt;

  assign w_accept    = in_valid & r_in_ready;
  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
  assign w_len_full  = {in_data, r_len[7:0]};
  assign w_len_over  = 32'(w_len_full) > DEPTH;
  assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_len);
  assign w_csum_ok   = (in_data == r_csum);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, plus output levels derived from the state being entered so
  // the registered outputs line up with the state register.
  always_comb begin
    w_next_state    = r_state;
    w_in_ready_nxt  = 1'b0;
    w_core_hold_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_next_state = S_LEN0;
      end
      S_LEN0: begin
        if (w_accept) w_next_state = S_LEN1;
      end
      S_LEN1: begin
        if (w_accept) begin
          if (w_len_over)              w_next_state = S_ERROR;
          else if (w_len_full == 16'd0) w_next_state = S_CSUM;
          else                          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word) w_next_state = S_CSUM;
      end
      S_CSUM: begin
        if (w_accept) w_next_state = w_csum_ok ? S_DONE : S_ERROR;
      end
      default: w_next_state = S_IDLE;
    endcase

    case (w_next_state)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: begin
        w_in_ready_nxt  = 1'b1;
        w_core_hold_nxt = 1'b1;
      end
      S_ERROR: begin
        w_core_hold_nxt = 1'b1;
        w_error_nxt     = 1'b1;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, word assembly, checksum and progMem write port.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_in_ready  <= 1'b0;
      r_pm_we     <= 1'b0;
      r_pm_addr   <= '0;
      r_pm_wdata  <= 32'd0;
      r_core_hold <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_len       <= 16'd0;
      r_word_idx  <= '0;
      r_byte_idx  <= 2'd0;
      r_asm       <= 24'd0;
      r_csum      <= 8'd0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_core_hold <= w_core_hold_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_pm_we     <= 1'b0;

      if (w_start_ok) begin
        r_len      <= 16'd0;
        r_word_idx <= '0;
        r_byte_idx <= 2'd0;
        r_asm      <= 24'd0;
        r_csum     <= 8'd0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN0: r_len[7:0] <= in_data;
          S_LEN1: r_len      <= w_len_full;
          S_DATA: begin
            r_csum     <= r_csum ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= in_data;
              2'd1: r_asm[15:8]  <= in_data;
              2'd2: r_asm[23:16] <= in_data;
              default: begin
                // Output registers are separate from r_asm, so the next
                // word can start assembling while this one is written.
                r_pm_wdata <= {in_data, r_asm};
                r_pm_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                r_pm_we    <= 1'b1;
                r_word_idx <= r_word_idx + IDX_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign pm_we     = r_pm_we;
  assign pm_addr   = r_pm_addr;
  assign pm_wdata  = r_pm_wdata;
  assign core_hold = r_core_hold;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (ADDR_WIDTH=4 so overflow and full-depth
// loads stay short).
module tb_prog_loader;

  localparam int unsigned AW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [31:0]   pm_wdata;
  logic          core_hold;
  logic          done;
  logic          error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  int            acc_q[$];
  logic [7:0]    stream_q[$];

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Record every progMem write with the cycle it was seen in
  always @(negedge Clock) begin
    if (pm_we === 1'b1) begin
      wa_q.push_back(pm_addr);
      wd_q.push_back(pm_wdata);
      wc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge Clock); #1;
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    int  waited = 0;
    bit  ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && waited < 20) begin
      @(negedge Clock);
      if (in_ready === 1'b1) ok = 1;
      else waited++;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
    end else begin
      acc_q.push_back(cyc);
      if (with_start) start = 1'b1;
      @(posedge Clock); #1;
      start = 1'b0;
    end
  endtask

  task automatic send_stream(input bit gaps, input int start_at);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (gaps && (i % 3) != 0) begin
        in_valid = 1'b0;
        repeat (i % 3) @(posedge Clock);
        #1;
      end
      send_byte(stream_q[i], i == start_at);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic build_normal(input logic [7:0] cs);
    stream_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, cs};
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({in_ready, pm_we, core_hold, done, error, pm_addr, pm_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h required all 0",
               in_ready, pm_we, core_hold, done, error, pm_addr, pm_wdata);
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clock);
    n_tests++;
    if ({in_ready, core_hold, done, error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b hold=%b done=%b err=%b required 0000",
               in_ready, core_hold, done, error);
    end
  endtask

  task automatic test_normal_load();
    clear_mon();
    pulse_start();
    n_tests++;
    if ({in_ready, core_hold, done, error} !== 4'b1100) begin
      n_fail++;
      $display("FAIL start_levels: got rdy=%b hold=%b done=%b err=%b required 1100",
               in_ready, core_hold, done, error);
    end
    build_normal(8'h2A);
    send_stream(1'b0, -1);
    n_tests++;
    if ({done, error, core_hold, in_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL normal_flags: got done=%b err=%b hold=%b rdy=%b required 1000",
               done, error, core_hold, in_ready);
    end
    n_tests++;
    if (wa_q.size() !== 2) begin
      n_fail++;
      $display("FAIL normal_write_count: got %0d required 2", wa_q.size());
    end else begin
      n_tests++;
      if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h12345678) begin
        n_fail++;
        $display("FAIL normal_word0: got addr=%h data=%h required 0 12345678", wa_q[0], wd_q[0]);
      end
      n_tests++;
      if (wa_q[1] !== 4'd1 || wd_q[1] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL normal_word1: got addr=%h data=%h required 1 deadbeef", wa_q[1], wd_q[1]);
      end
    end
    n_tests++;
    if (pm_addr !== 4'd1 || pm_wdata !== 32'hDEADBEEF || pm_we !== 1'b0) begin
      n_fail++;
      $display("FAIL write_port_hold: got we=%b addr=%h data=%h required 0 1 deadbeef",
               pm_we, pm_addr, pm_wdata);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    pulse_start();
    build_normal(8'h2A);
    send_stream(1'b0, -1);
    n_tests++;
    if (wc_q.size() !== 2 || acc_q.size() !== 11) begin
      n_fail++;
      $display("FAIL b2b_counts: got writes=%0d bytes=%0d required 2 11", wc_q.size(), acc_q.size());
    end else begin
      n_tests++;
      if (wc_q[0] !== acc_q[5] + 1 || wc_q[1] !== acc_q[9] + 1) begin
        n_fail++;
        $display("FAIL b2b_write_timing: got we cycles %0d,%0d required %0d,%0d",
                 wc_q[0], wc_q[1], acc_q[5] + 1, acc_q[9] + 1);
      end
      n_tests++;
      if (acc_q[10] - acc_q[0] !== 10) begin
        n_fail++;
        $display("FAIL b2b_throughput: got %0d cycles for 11 bytes required 10", acc_q[10] - acc_q[0]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    clear_mon();
    pulse_start();
    build_normal(8'h2B);
    send_stream(1'b0, -1);
    n_tests++;
    if ({error, core_hold, done, in_ready} !== 4'b1100) begin
      n_fail++;
      $display("FAIL badcs_flags: got err=%b hold=%b done=%b rdy=%b required 1100",
               error, core_hold, done, in_ready);
    end
    n_tests++;
    if (wa_q.size() !== 2) begin
      n_fail++;
      $display("FAIL badcs_write_count: got %0d required 2", wa_q.size());
    end else begin
      n_tests++;
      if (wd_q[0] !== 32'h12345678 || wd_q[1] !== 32'hDEADBEEF || wa_q[1] !== 4'd1) begin
        n_fail++;
        $display("FAIL badcs_writes: got %h@0 %h@%h required 12345678@0 deadbeef@1",
                 wd_q[0], wd_q[1], wa_q[1]);
      end
    end
  endtask

  task automatic test_empty();
    clear_mon();
    pulse_start();
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(1'b0, -1);
    n_tests++;
    if ({done, error, core_hold} !== 3'b100) begin
      n_fail++;
      $display("FAIL empty_flags: got done=%b err=%b hold=%b required 100", done, error, core_hold);
    end
    n_tests++;
    if (wa_q.size() !== 0) begin
      n_fail++;
      $display("FAIL empty_writes: got %0d required 0", wa_q.size());
    end
  endtask

  task automatic test_gaps_and_start();
    clear_mon();
    pulse_start();
    build_normal(8'h2A);
    send_stream(1'b1, 4);
    n_tests++;
    if ({done, error, core_hold} !== 3'b100) begin
      n_fail++;
      $display("FAIL gaps_flags: got done=%b err=%b hold=%b required 100", done, error, core_hold);
    end
    n_tests++;
    if (wa_q.size() !== 2) begin
      n_fail++;
      $display("FAIL gaps_write_count: got %0d required 2", wa_q.size());
    end else begin
      n_tests++;
      if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h12345678 ||
          wa_q[1] !== 4'd1 || wd_q[1] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL gaps_writes: got %h@%h %h@%h required 12345678@0 deadbeef@1",
                 wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    pulse_start();
    stream_q = '{8'h11, 8'h00};
    send_stream(1'b0, -1);
    n_tests++;
    if ({error, in_ready, core_hold, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL overflow_flags: got err=%b rdy=%b hold=%b done=%b required 1010",
               error, in_ready, core_hold, done);
    end
    repeat (4) @(negedge Clock);
    n_tests++;
    if (wa_q.size() !== 0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_no_write: got writes=%0d rdy=%b required 0 0", wa_q.size(), in_ready);
    end
  endtask

  task automatic test_full_depth();
    logic [31:0] exp_w[16];
    logic [7:0]  cs;
    int          bad;
    cs = 8'd0;
    bad = 0;
    stream_q = '{8'h10, 8'h00};
    for (int i = 0; i < 16; i++) begin
      exp_w[i] = {8'(i * 16 + 3), 8'(i * 7), 8'(8'hA0 ^ 8'(i)), 8'(i + 1)};
      for (int k = 0; k < 4; k++) begin
        stream_q.push_back(exp_w[i][8*k +: 8]);
        cs = cs ^ exp_w[i][8*k +: 8];
      end
    end
    stream_q.push_back(cs);
    clear_mon();
    pulse_start();
    send_stream(1'b0, -1);
    n_tests++;
    if ({done, error, core_hold} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_flags: got done=%b err=%b hold=%b required 100", done, error, core_hold);
    end
    n_tests++;
    if (wa_q.size() !== 16) begin
      n_fail++;
      $display("FAIL full_write_count: got %0d required 16", wa_q.size());
    end else begin
      for (int i = 0; i < 16; i++)
        if (wa_q[i] !== 4'(i) || wd_q[i] !== exp_w[i]) bad++;
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL full_writes: got %0d wrong words required 0 (last %h@%h)", bad, wd_q[15], wa_q[15]);
      end
    end
  endtask

  task automatic test_reset_midload();
    clear_mon();
    pulse_start();
    build_normal(8'h2A);
    for (int i = 0; i < 7; i++) send_byte(stream_q[i], 1'b0);
    Reset = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, pm_we, core_hold, done, error, pm_addr, pm_wdata} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h required all 0",
               in_ready, pm_we, core_hold, done, error, pm_addr, pm_wdata);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (5) @(negedge Clock);
    n_tests++;
    if (wa_q.size() !== 1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_write: got writes=%0d rdy=%b required 1 0", wa_q.size(), in_ready);
    end
    clear_mon();
    pulse_start();
    send_stream(1'b0, -1);
    n_tests++;
    if (wa_q.size() !== 2 || done !== 1'b1 || core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_summary: got writes=%0d done=%b hold=%b required 2 1 0",
               wa_q.size(), done, core_hold);
    end else begin
      n_tests++;
      if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h12345678 ||
          wa_q[1] !== 4'd1 || wd_q[1] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL reload_writes: got %h@%h %h@%h required 12345678@0 deadbeef@1",
                 wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_back_to_back();
    test_bad_checksum();
    test_empty();
    test_gaps_and_start();
    test_overflow();
    test_full_depth();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that fills the core's instruction memory from a byte stream before execution begins. It accepts bytes over a valid/ready handshake and assembles them into little-endian 32-bit words. Each word is written through a dedicated progMem write port, and the stream is checked against a trailing XOR checksum. While loading, the block holds the core in `hold` via `core_hold`, so the fetch side never reads a partially written program.

## Interface

Parameters:
- `ADDR_WIDTH`, default 10: progMem word-address width. DEPTH = 2^ADDR_WIDTH words.

Ports (reset is asynchronous, active-high, on `Reset`; `Clock` is the only clock):
- `Clock` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous active-high reset.
- `start` in 1: single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a byte. A byte transfers when `in_valid && in_ready`.
- `pm_we` out 1: progMem write strobe, one cycle per word.
- `pm_addr` out ADDR_WIDTH: progMem word address.
- `pm_wdata` out 32: progMem write data.
- `core_hold` out 1: stalls the core's fetch/PC while asserted.
- `done` out 1: level; load completed with a good checksum.
- `error` out 1: level; load failed (checksum mismatch or length overflow).

## Operation

- Stream format:
  - Two length bytes, N = word count, low byte first.
  - N×4 data bytes, little-endian per word.
  - One checksum byte = XOR of all data bytes (length bytes excluded).
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- State transitions:
  - IDLE/DONE/ERROR + `start` → LEN0. This clears `done`, `error`, the checksum accumulator, the word index and the byte index.
  - LEN0: accept byte → LEN1.
  - LEN1: accept byte, then:
    - if N > DEPTH → ERROR;
    - else if N == 0 → CSUM;
    - else → DATA.
  - DATA: each accepted byte is placed at bits [8·k+7:8·k] of the assembly register, where k = byte index 0..3, and XORed into the checksum.
    - On k==3 the assembled word is registered into `pm_wdata` and the word index into `pm_addr`.
    - `pm_we` pulses on the next cycle, and the word index then increments.
    - After the 4th byte of word N-1 → CSUM.
  - CSUM: accept byte; equal to the accumulator → DONE, otherwise → ERROR.
- `start` in LEN0/LEN1/DATA/CSUM is ignored.
- Output levels:
  - `in_ready` = 1 in LEN0, LEN1, DATA and CSUM; 0 in all other states.
  - `core_hold` = 1 in LEN0 through CSUM and in ERROR; 0 in IDLE and DONE.
  - `done` = 1 only in DONE; `error` = 1 only in ERROR.
- Words already written before an ERROR remain in progMem. The core stays held until the next successful load or `Reset`.
- The length is 16 bits wide; the word index is ADDR_WIDTH+1 bits wide, so N == DEPTH completes without wrap.

## Timing

- Reset values, applied immediately while `Reset` is high:
  - state IDLE;
  - `in_ready`, `pm_we`, `pm_addr`, `pm_wdata`, `core_hold`, `done`, `error` all 0;
  - internal counters and accumulator 0.
- Throughput: one byte per cycle with `in_valid` held high. No backpressure occurs in DATA.
  - `pm_we` for word i appears one cycle after its 4th byte is accepted.
  - That write overlaps acceptance of byte 0 of word i+1. The assembly register and the output registers are separate, so this is legal.
- `pm_addr` and `pm_wdata` hold their values until the next write.
- A gap in `in_valid` stalls progress with no state change and no partial-word write.
- `done`/`error`/`core_hold` update on the clock edge that accepts the checksum byte. Their new levels are visible in the following cycle.
- `start` takes effect on the next edge; `in_ready` rises one cycle after `start`.
- `Reset` mid-load aborts the load.
  - No `pm_we` is issued after `Reset` asserts.
  - The next `start` reloads from address 0.

## Test plan

- Normal load: `start`; bytes 02 00, 78 56 34 12, EF BE AD DE, 2A.
  - Required: `pm_we` writes addr 0 = 0x12345678, then addr 1 = 0xDEADBEEF.
  - Required: `done`=1, `core_hold`=0, `error`=0.
- Bad checksum: same stream, final byte 2B.
  - Required: both writes still occur; `error`=1, `core_hold` stays 1, `done`=0.
- Empty program: `start`; bytes 00 00, 00.
  - Required: no `pm_we`; `done`=1, `core_hold`=0.
- Stream rate:
  - Back-to-back bytes: each `pm_we` exactly one cycle after its 4th byte.
  - Random `in_valid` gaps: identical writes and final flags.
  - `start` mid-load is ignored.
- Length overflow, ADDR_WIDTH=4: bytes 11 00 (N=17).
  - Required: ERROR right after LEN1, no `pm_we`, `in_ready`=0.
  - With N=16: all 16 writes (addr 0..15), correct checksum → DONE.
- Reset mid-load: `Reset` pulsed after 5 data bytes.
  - Required: all outputs 0 at once, no further `pm_we`.
  - The next `start` plus the normal-load stream reproduces the normal-load result from addr 0.
